// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with preset, start/pause and timed alarm.
// State encoding:
//   state     | meaning
//   S_IDLE    | stopped; holds preset or 00:00, waiting for START
//   S_RUN     | decrementing one second per TICK
//   S_PAUSE   | suspended mid-count, waiting for START
//   S_EXPIRED | count reached 00:00; ALARM high while TICKs are counted
module countdown_timer #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic       START,
  input  logic       PAUSE,
  input  logic [3:0] PRE_MT,
  input  logic [3:0] PRE_MU,
  input  logic [3:0] PRE_ST,
  input  logic [3:0] PRE_SU,
  output logic [3:0] MT,
  output logic [3:0] MU,
  output logic [3:0] ST,
  output logic [3:0] SU,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [7:0] ALARM_LOAD = ALARM_TICKS[7:0];

  logic [1:0] state;
  logic [7:0] alarm_cnt;

  logic [3:0] dec_mt, dec_mu, dec_st, dec_su;
  logic       b_su, b_st, b_mu;
  logic       at_zero, at_one;

  logic [3:0] clamp_mt, clamp_mu, clamp_st, clamp_su;

  assign at_zero = (MT == 4'd0) && (MU == 4'd0) && (ST == 4'd0) && (SU == 4'd0);
  assign at_one  = (MT == 4'd0) && (MU == 4'd0) && (ST == 4'd0) && (SU == 4'd1);

  assign clamp_mt = (PRE_MT > 4'd5) ? 4'd5 : PRE_MT;
  assign clamp_mu = (PRE_MU > 4'd9) ? 4'd9 : PRE_MU;
  assign clamp_st = (PRE_ST > 4'd5) ? 4'd5 : PRE_ST;
  assign clamp_su = (PRE_SU > 4'd9) ? 4'd9 : PRE_SU;

  // One-second decrement with BCD borrow ripple; only used when count is nonzero.
  always_comb begin
    dec_su = SU - 4'd1;
    b_su   = 1'b0;
    if (SU == 4'd0) begin
      dec_su = 4'd9;
      b_su   = 1'b1;
    end
    dec_st = ST;
    b_st   = 1'b0;
    if (b_su) begin
      if (ST == 4'd0) begin
        dec_st = 4'd5;
        b_st   = 1'b1;
      end else begin
        dec_st = ST - 4'd1;
      end
    end
    dec_mu = MU;
    b_mu   = 1'b0;
    if (b_st) begin
      if (MU == 4'd0) begin
        dec_mu = 4'd9;
        b_mu   = 1'b1;
      end else begin
        dec_mu = MU - 4'd1;
      end
    end
    dec_mt = MT;
    if (b_mu) begin
      dec_mt = MT - 4'd1;
    end
  end

  // Control FSM, digit registers, alarm down-counter and registered flags.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state     <= S_IDLE;
      MT        <= 4'd0;
      MU        <= 4'd0;
      ST        <= 4'd0;
      SU        <= 4'd0;
      RUNNING   <= 1'b0;
      DONE      <= 1'b0;
      ALARM     <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      DONE <= 1'b0;
      if (LOAD) begin
        MT        <= clamp_mt;
        MU        <= clamp_mu;
        ST        <= clamp_st;
        SU        <= clamp_su;
        state     <= S_IDLE;
        RUNNING   <= 1'b0;
        ALARM     <= 1'b0;
        alarm_cnt <= 8'd0;
      end else begin
        case (state)
          S_RUN: begin
            if (PAUSE) begin
              state   <= S_PAUSE;
              RUNNING <= 1'b0;
            end else if (TICK && !at_zero) begin
              MT <= dec_mt;
              MU <= dec_mu;
              ST <= dec_st;
              SU <= dec_su;
              if (at_one) begin
                state     <= S_EXPIRED;
                RUNNING   <= 1'b0;
                DONE      <= 1'b1;
                ALARM     <= 1'b1;
                alarm_cnt <= ALARM_LOAD;
              end
            end
          end
          S_IDLE, S_PAUSE: begin
            // A simultaneous PAUSE suppresses START.
            if (START && !PAUSE && !at_zero) begin
              state   <= S_RUN;
              RUNNING <= 1'b1;
            end
          end
          S_EXPIRED: begin
            if (TICK) begin
              if (alarm_cnt <= 8'd1) begin
                state     <= S_IDLE;
                ALARM     <= 1'b0;
                alarm_cnt <= 8'd0;
              end else begin
                alarm_cnt <= alarm_cnt - 8'd1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
